// File: rtl/ahb_xcorr_regfile.sv
// ahb_xcorr_regfile
//   AHB-Lite slave register file for a cross-correlator block.
//   Offsets (haddr[15:0]): 0x0000 CTRL, 0x0004 STATUS (W1C), 0x0008 CFG,
//   0x0100+8i RES_X[i], 0x0104+8i RES_Y[i] (read-only shadows).
// Ports
//   hclk, hresetn           : clock, async active-low reset
//   hsel/hwrite/hready_in   : AHB select, direction, bus ready
//   haddr/htrans/hsize      : AHB address-phase controls (hburst ignored)
//   hwdata                  : write data (sampled at the end of the data phase)
//   res_x/res_y/res_valid   : correlator results, channel i at [32i+31:32i]
//   hreadyout/hresp/hrdata  : AHB response
//   cfg, start, irq         : CFG contents, start pulse, level interrupt
module ahb_xcorr_regfile #(
    parameter int          NUM_CH      = 4,
    parameter logic [3:0]  BASE_NIBBLE = 4'h8,
    parameter int          RD_WAIT     = 0
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic                  hsel,
    input  logic                  hwrite,
    input  logic                  hready_in,
    input  logic [31:0]           haddr,
    input  logic [1:0]            htrans,
    input  logic [2:0]            hsize,
    input  logic [2:0]            hburst,
    input  logic [31:0]           hwdata,
    input  logic [NUM_CH*32-1:0]  res_x,
    input  logic [NUM_CH*32-1:0]  res_y,
    input  logic                  res_valid,
    output logic                  hreadyout,
    output logic [1:0]            hresp,
    output logic [31:0]           hrdata,
    output logic [31:0]           cfg,
    output logic                  start,
    output logic                  irq
);
    typedef enum logic [2:0] {S_IDLE, S_RDW, S_DATA, S_ERR1, S_ERR2} state_t;

    localparam logic [1:0] WAIT_LAST = (RD_WAIT > 0) ? 2'(RD_WAIT - 1) : 2'd0;
    localparam logic [5:0] NCH       = 6'(NUM_CH);

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [15:0] addr_q;
    logic        write_q;
    logic [2:0]  size_q;
    logic        irq_en_q, done_q, ovr_q, start_q;
    logic        done_d, ovr_d;
    logic [31:0] cfg_q;
    logic [31:0] rx_q [NUM_CH];
    logic [31:0] ry_q [NUM_CH];

    logic        open_slot, take, bad, wr_commit, wr_ctrl, wr_stat, wr_cfg;
    logic [31:0] rd_val;
    logic        unused_ok;

    assign unused_ok = ^{hburst, haddr[27:16], htrans[0]};

    function automatic logic is_res(input logic [15:0] off);
        return (off[15:8] == 8'h01) && ({1'b0, off[7:3]} < NCH) && (off[1:0] == 2'b00);
    endfunction

    function automatic logic is_rw(input logic [15:0] off);
        return (off == 16'h0000) || (off == 16'h0004) || (off == 16'h0008);
    endfunction

    // A new address phase can only be taken while the bus is not stalled by us.
    assign open_slot = (state_q == S_IDLE) || (state_q == S_DATA) || (state_q == S_ERR2);
    assign take      = open_slot & hsel & htrans[1] & hready_in & (haddr[31:28] == BASE_NIBBLE);
    assign bad       = (hsize != 3'b010)
                     || !(is_rw(haddr[15:0]) || is_res(haddr[15:0]))
                     || (hwrite && is_res(haddr[15:0]));

    // Only decode-clean writes ever reach S_DATA, so errors never commit.
    assign wr_commit = (state_q == S_DATA) && write_q && (size_q == 3'b010);
    assign wr_ctrl   = wr_commit && (addr_q == 16'h0000);
    assign wr_stat   = wr_commit && (addr_q == 16'h0004);
    assign wr_cfg    = wr_commit && (addr_q == 16'h0008);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_RDW: begin
                if (cnt_q == WAIT_LAST) state_d = S_DATA;
                else                    cnt_d   = cnt_q + 2'd1;
            end
            S_ERR1: state_d = S_ERR2;
            default: begin
                // IDLE / final data cycle: pipelined next transfer starts here
                state_d = S_IDLE;
                if (take) begin
                    cnt_d = 2'd0;
                    if (bad)                          state_d = S_ERR1;
                    else if (!hwrite && RD_WAIT > 0)  state_d = S_RDW;
                    else                              state_d = S_DATA;
                end
            end
        endcase
    end

    // Set wins over a coincident W1C; overrun looks at DONE before this edge.
    always_comb begin
        done_d = (done_q & ~(wr_stat & hwdata[0])) | res_valid;
        ovr_d  = (ovr_q  & ~(wr_stat & hwdata[1])) | (res_valid & done_q);
    end

    always_comb begin
        rd_val = 32'h0;
        if (addr_q == 16'h0000)      rd_val = {30'h0, irq_en_q, 1'b0};
        else if (addr_q == 16'h0004) rd_val = {30'h0, ovr_q, done_q};
        else if (addr_q == 16'h0008) rd_val = cfg_q;
        else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (addr_q[15:8] == 8'h01 && addr_q[6:3] == 4'(i))
                    rd_val = addr_q[2] ? ry_q[i] : rx_q[i];
            end
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q  <= S_IDLE;
            cnt_q    <= 2'd0;
            addr_q   <= 16'h0;
            write_q  <= 1'b0;
            size_q   <= 3'b0;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            ovr_q    <= 1'b0;
            start_q  <= 1'b0;
            cfg_q    <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (take) begin
                addr_q  <= haddr[15:0];
                write_q <= hwrite;
                size_q  <= hsize;
            end
            if (wr_ctrl) irq_en_q <= hwdata[1];
            if (wr_cfg)  cfg_q    <= hwdata;
            start_q <= wr_ctrl & hwdata[0];
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            for (int i = 0; i < NUM_CH; i++) begin
                rx_q[i] <= 32'h0;
                ry_q[i] <= 32'h0;
            end
        end else if (res_valid) begin
            for (int i = 0; i < NUM_CH; i++) begin
                rx_q[i] <= res_x[32*i +: 32];
                ry_q[i] <= res_y[32*i +: 32];
            end
        end
    end

    assign hreadyout = !((state_q == S_RDW) || (state_q == S_ERR1));
    assign hresp     = ((state_q == S_ERR1) || (state_q == S_ERR2)) ? 2'b01 : 2'b00;
    assign hrdata    = ((state_q == S_DATA) && !write_q) ? rd_val : 32'h0;
    assign cfg       = cfg_q;
    assign start     = start_q;
    assign irq       = irq_en_q & done_q;
endmodule

// File: tb/tb_ahb_xcorr_regfile.sv
// tb_ahb_xcorr_regfile
//   Transaction-level model of the register file; every cycle the compare
//   process checks the bus response, start, irq and cfg against it.
module tb_ahb_xcorr_regfile;
    localparam int NCH = 4;
    localparam int RDW = 2;

    logic              hclk = 1'b0;
    logic              hresetn = 1'b1;
    logic              hsel = 1'b0, hwrite = 1'b0;
    logic              hready_in;
    logic [31:0]       haddr = '0;
    logic [1:0]        htrans = '0;
    logic [2:0]        hsize = '0, hburst = '0;
    logic [31:0]       hwdata = '0;
    logic [NCH*32-1:0] res_x = '0, res_y = '0;
    logic              res_valid = 1'b0;
    logic              hreadyout, start, irq;
    logic [1:0]        hresp;
    logic [31:0]       hrdata, cfg;

    assign hready_in = hreadyout;

    ahb_xcorr_regfile #(.NUM_CH(NCH), .BASE_NIBBLE(4'h8), .RD_WAIT(RDW)) dut (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel), .hwrite(hwrite),
        .hready_in(hready_in), .haddr(haddr), .htrans(htrans), .hsize(hsize),
        .hburst(hburst), .hwdata(hwdata), .res_x(res_x), .res_y(res_y),
        .res_valid(res_valid), .hreadyout(hreadyout), .hresp(hresp),
        .hrdata(hrdata), .cfg(cfg), .start(start), .irq(irq)
    );

    always #5 hclk = ~hclk;

    // model state
    bit          m_en, m_done, m_ov, m_start;
    logic [31:0] m_cfg;
    logic [31:0] m_rx [NCH];
    logic [31:0] m_ry [NCH];
    bit          pend;
    logic [15:0] pend_off;
    logic [31:0] pend_dat;
    // expectations for the current cycle
    bit          exp_rdy, exp_rdfin, chk_en, rv_rand;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata, last_rd;
    int          n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge hclk) begin
        if (chk_en) begin
            chk("hreadyout", 32'(hreadyout), 32'(exp_rdy));
            chk("hresp",     32'(hresp),     32'(exp_resp));
            chk("hrdata",    hrdata,         exp_rdata);
            chk("start",     32'(start),     32'(m_start));
            chk("irq",       32'(irq),       32'(m_en & m_done));
            chk("cfg",       cfg,            m_cfg);
            if (exp_rdfin) last_rd = hrdata;
        end
    end

    function automatic bit model_err(input bit wr, input logic [15:0] off, input logic [2:0] sz);
        int  o;
        bit  res, mapped;
        o      = int'(off);
        res    = (o >= 256) && (o < 256 + 8 * NCH) && (o % 4 == 0);
        mapped = (o == 0) || (o == 4) || (o == 8) || res;
        return (sz != 3'd2) || !mapped || (wr && res);
    endfunction

    function automatic logic [31:0] model_read(input logic [15:0] off);
        int o;
        o = int'(off);
        if (o == 0) return m_en ? 32'h2 : 32'h0;
        if (o == 4) return (m_ov ? 32'h2 : 32'h0) | (m_done ? 32'h1 : 32'h0);
        if (o == 8) return m_cfg;
        return ((o - 256) % 8 == 0) ? m_rx[(o - 256) / 8] : m_ry[(o - 256) / 8];
    endfunction

    task automatic model_reset();
        m_en = 0; m_done = 0; m_ov = 0; m_start = 0; m_cfg = '0; pend = 0;
        for (int i = 0; i < NCH; i++) begin m_rx[i] = '0; m_ry[i] = '0; end
    endtask

    // Advance one clock; apply the edge's effects to the model; then drive a
    // non-accepted bus pattern with idle expectations for the new cycle.
    task automatic tick();
        bit rv, cd, co;
        logic [NCH*32-1:0] rx, ry;
        rv = res_valid; rx = res_x; ry = res_y; cd = 0; co = 0;
        @(posedge hclk);
        m_start = 0;
        if (pend) begin
            if (pend_off == 16'h0000)      begin m_en = pend_dat[1]; m_start = pend_dat[0]; end
            else if (pend_off == 16'h0004) begin cd = pend_dat[0]; co = pend_dat[1]; end
            else if (pend_off == 16'h0008) m_cfg = pend_dat;
        end
        m_ov   = (m_ov & ~co) | (rv & m_done);
        m_done = (m_done & ~cd) | rv;
        if (rv) begin
            for (int i = 0; i < NCH; i++) begin
                m_rx[i] = rx[32*i +: 32];
                m_ry[i] = ry[32*i +: 32];
            end
        end
        pend = 0;
        #1;
        exp_rdy = 1; exp_resp = 2'b00; exp_rdata = '0; exp_rdfin = 0;
        case ($urandom_range(0, 2))
            0:       begin hsel = 0; htrans = 2'($urandom); haddr = {4'h8, 28'($urandom)}; end
            1:       begin hsel = 1; htrans = {1'b0, 1'($urandom)}; haddr = {4'h8, 28'($urandom)}; end
            default: begin hsel = 1; htrans = 2'b10; haddr = {4'($urandom_range(0, 7)), 28'($urandom)}; end
        endcase
        hwrite = 1'($urandom); hsize = 3'($urandom); hburst = 3'($urandom); hwdata = $urandom;
        res_valid = 0;
        if (rv_rand && $urandom_range(0, 5) == 0) begin
            res_valid = 1;
            for (int i = 0; i < NCH; i++) begin
                res_x[32*i +: 32] = $urandom;
                res_y[32*i +: 32] = $urandom;
            end
        end
    endtask

    // Drives the address phase in the current cycle; returns in the final
    // data cycle (caller either pipelines the next transfer or ticks).
    task automatic do_xfer(input bit wr, input logic [15:0] off, input logic [2:0] sz,
                           input logic [31:0] wd);
        bit err;
        err    = model_err(wr, off, sz);
        hsel   = 1; htrans = $urandom_range(0, 1) ? 2'b10 : 2'b11;
        haddr  = {4'h8, 12'($urandom), off}; hwrite = wr; hsize = sz;
        tick();
        hwdata = wd;
        if (err) begin
            exp_rdy = 0; exp_resp = 2'b01;
            tick();
            exp_resp = 2'b01;
        end else if (!wr) begin
            repeat (RDW) begin exp_rdy = 0; tick(); end
            exp_rdata = model_read(off); exp_rdfin = 1;
        end else begin
            pend = 1; pend_off = off; pend_dat = wd;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] off;
        logic [2:0]  sz;
        bit          wr;
        model_reset();
        chk_en = 0; rv_rand = 0; last_rd = '0;
        exp_rdy = 1; exp_resp = 0; exp_rdata = 0; exp_rdfin = 0;
        #1 hresetn = 0;
        #2;
        chk("rst_hreadyout", 32'(hreadyout), 32'h1);
        chk("rst_hresp",     32'(hresp),     32'h0);
        chk("rst_cfg",       cfg,            32'h0);
        chk("rst_irq_start", {30'h0, irq, start}, 32'h0);
        @(posedge hclk); #1;
        hresetn = 1;
        chk_en = 1;

        // address phase taken on the very first edge after release
        do_xfer(1, 16'h0008, 3'b010, 32'hDEADBEEF);
        do_xfer(0, 16'h0008, 3'b010, 32'h0);
        tick();
        chk("lit_cfg_out", cfg, 32'hDEADBEEF);
        chk("lit_cfg_rd",  last_rd, 32'hDEADBEEF);

        res_x = '0; res_x[2*32 +: 32] = 32'h123; res_valid = 1;
        tick();
        do_xfer(0, 16'h0110, 3'b010, 0); tick();
        chk("lit_resx2", last_rd, 32'h123);
        do_xfer(0, 16'h0004, 3'b010, 0); tick();
        chk("lit_status1", last_rd, 32'h1);
        res_valid = 1; tick();
        do_xfer(0, 16'h0004, 3'b010, 0); tick();
        chk("lit_status3", last_rd, 32'h3);
        do_xfer(1, 16'h0004, 3'b010, 32'h3);
        do_xfer(0, 16'h0004, 3'b010, 0); tick();
        chk("lit_status0", last_rd, 32'h0);

        // error cases leave everything untouched
        do_xfer(1, 16'h0100, 3'b010, 32'h5);
        do_xfer(0, 16'h0200, 3'b010, 0);
        do_xfer(1, 16'h0008, 3'b000, 32'h0);
        do_xfer(0, 16'h0008, 3'b010, 0); tick();
        chk("lit_cfg_kept", last_rd, 32'hDEADBEEF);
        do_xfer(0, 16'h0100, 3'b010, 0); tick();
        chk("lit_resx0_kept", last_rd, 32'h0);

        do_xfer(1, 16'h0000, 3'b010, 32'h3); tick();
        chk("lit_start_hi", 32'(start), 32'h1);
        tick();
        chk("lit_start_lo", 32'(start), 32'h0);
        do_xfer(0, 16'h0000, 3'b010, 0); tick();
        chk("lit_ctrl_rd", last_rd, 32'h2);
        res_valid = 1; tick();
        chk("lit_irq", 32'(irq), 32'h1);
        do_xfer(1, 16'h0004, 3'b010, 32'h1);
        res_valid = 1;
        do_xfer(0, 16'h0004, 3'b010, 0); tick();
        chk("lit_set_wins_ov", last_rd, 32'h3);
        do_xfer(1, 16'h0004, 3'b010, 32'h3); tick();
        do_xfer(1, 16'h0004, 3'b010, 32'h1);
        res_valid = 1;
        do_xfer(0, 16'h0004, 3'b010, 0); tick();
        chk("lit_set_wins", last_rd, 32'h1);

        // randomized traffic with random result pulses
        rv_rand = 1;
        for (int n = 0; n < 400; n++) begin
            wr = 1'($urandom);
            case ($urandom_range(0, 9))
                0, 1:    off = 16'h0000;
                2, 3:    off = 16'h0004;
                4, 5:    off = 16'h0008;
                6, 7:    off = 16'h0100 + 16'($urandom_range(0, 2 * NCH - 1) * 4);
                8:       off = 16'h0100 + 16'(8 * NCH);
                default: off = 16'($urandom_range(0, 65535));
            endcase
            sz = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b010;
            do_xfer(wr, off, sz, $urandom);
            if ($urandom_range(0, 1) == 0) begin
                tick();
                repeat ($urandom_range(0, 2)) tick();
            end
        end
        tick();

        // reset during a read stall
        rv_rand = 0; res_valid = 0;
        tick();
        hsel = 1; htrans = 2'b10; haddr = 32'h8000_0004; hwrite = 0; hsize = 3'b010;
        exp_rdy = 1;
        tick();
        chk_en = 0;
        hsel = 0; htrans = 2'b00;
        #1 hresetn = 0;
        #1;
        chk("stall_rst_hreadyout", 32'(hreadyout), 32'h1);
        chk("stall_rst_hresp",     32'(hresp),     32'h0);
        chk("stall_rst_hrdata",    hrdata,         32'h0);
        chk("stall_rst_cfg",       cfg,            32'h0);
        chk("stall_rst_irq_start", {30'h0, irq, start}, 32'h0);
        model_reset();
        res_valid = 0;
        @(posedge hclk); #1;
        hresetn = 1;
        exp_rdy = 1; exp_resp = 0; exp_rdata = 0; exp_rdfin = 0;
        chk_en = 1;
        do_xfer(0, 16'h0008, 3'b010, 0);
        do_xfer(0, 16'h0004, 3'b010, 0);
        do_xfer(0, 16'h0000, 3'b010, 0);
        do_xfer(0, 16'h0110, 3'b010, 0); tick();
        chk("lit_post_rst_res", last_rd, 32'h0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ahb_xcorr_regfile.md
AHB_XCORR_REGFILE -- requirements
Module: ahb_xcorr_regfile

Interface
REQ-001 Parameters (name, default, meaning): NUM_CH, 4, result channel pairs (1..16); BASE_NIBBLE, 4'h8, required haddr[31:28]; RD_WAIT, 0, read wait states (0..3).
REQ-002 hclk  in  1  sole clock; all state on rising edge.
REQ-003 hresetn  in  1  asynchronous active-low reset.
REQ-004 hsel, hwrite, hready_in  in  1 each  AHB select, direction, bus ready.
REQ-005 haddr  in  32; htrans  in  2; hsize  in  3; hburst  in  3 (ignored); hwdata  in  32.
REQ-006 res_x, res_y  in  NUM_CH*32  correlator max-sequence results, channel i at bits [32i+31:32i].
REQ-007 res_valid  in  1  one-cycle pulse: res_x/res_y valid.
REQ-008 hreadyout  out  1; hresp  out  2 (2'b00 OKAY, 2'b01 ERROR); hrdata  out  32.
REQ-009 cfg  out  32  CFG register contents; start  out  1  one-cycle start pulse; irq  out  1  level interrupt.

Function
REQ-010 Accepted address phase: hsel & htrans[1] & hready_in & haddr[31:28]==BASE_NIBBLE; the block shall register haddr[15:0], hwrite and hsize; non-accepted cycles leave the block idle.
REQ-011 Map (offset haddr[15:0]): 0x0000 CTRL RW; 0x0004 STATUS R/W1C; 0x0008 CFG RW; 0x0100+8i RES_X[i] RO; 0x0104+8i RES_Y[i] RO, i<NUM_CH.
REQ-012 CTRL: bit0 START (write 1 -> start high exactly one cycle after write data phase; reads 0); bit1 IRQ_EN (RW); other bits read 0.
REQ-013 STATUS: bit0 DONE, bit1 OVERRUN, sticky; writing 1 clears the bit, writing 0 no effect; other bits read 0.
REQ-014 Write data phase: hwdata sampled at the edge ending the data phase; register change visible the following cycle.
REQ-015 Read data phase: hreadyout low for RD_WAIT cycles, then high one cycle with hrdata = addressed value; hrdata = 0 outside a valid read completion.
REQ-016 Write data phases complete in one cycle with no wait states.
REQ-017 ERROR for unmapped offset, write to RO offset, or hsize != 3'b010: cycle 1 hreadyout=0 hresp=01; cycle 2 hreadyout=1 hresp=01; no register modified.
REQ-018 hresp shall be 2'b00 in all non-error cycles; hreadyout=1 when idle.
REQ-019 On res_valid: all RES_X/RES_Y shadow registers load res_x/res_y in the same edge; DONE set; if DONE already 1, OVERRUN set.
REQ-020 res_valid coincident with W1C of DONE: DONE remains 1 (set wins); OVERRUN not set by that event unless DONE was 1 before it.
REQ-021 Read of RES_* coincident with res_valid returns pre-update value.
REQ-022 irq = IRQ_EN & DONE, registered-free combinational from flops.
REQ-023 Back-to-back transfers: an address phase accepted during the prior transfer's final data cycle shall be honoured with no bubble.
REQ-024 State machine: IDLE, RD_WAIT (counter 0..RD_WAIT-1), DATA, ERR1, ERR2; ERR2 -> IDLE or new transfer per REQ-023.

Reset
REQ-025 hresetn low shall asynchronously force: CTRL, STATUS, CFG, RES_* = 0; start=0, irq=0, hrdata=0, hresp=00, hreadyout=1; FSM IDLE.
REQ-026 Reset asserted mid-transfer shall abort it; no partial register write occurs.
REQ-027 Reset release shall be synchronous-safe: first accepted address phase is the first rising edge with hresetn high.

Verification
REQ-028 Write 0x0008=0xDEADBEEF, read 0x0008 -> cfg=0xDEADBEEF next cycle, hrdata=0xDEADBEEF, hresp=00.
REQ-029 NUM_CH=4, res_valid with res_x[ch2]=0x123 -> read 0x0110 returns 0x123, STATUS=0x1; second res_valid -> STATUS=0x3; write STATUS=0x3 -> STATUS=0x0.
REQ-030 RD_WAIT=2, read 0x0004 -> hreadyout low 2 cycles, then high with hrdata valid.
REQ-031 Write 0x0100 or read 0x0200 or hsize=3'b000 -> two-cycle ERROR, registers unchanged.
REQ-032 Write CTRL=0x3 -> start high one cycle, CTRL reads 0x2; res_valid -> irq=1; W1C DONE same cycle as res_valid -> DONE stays 1.
REQ-033 Assert hresetn low during RD_WAIT stall -> hreadyout=1, all registers 0 immediately.
